binary_to_bcd_stream: RTL and testbench
=======================================

// Module: binary_to_bcd_stream
// PURPOSE
//  Streaming binary-to-BCD converter using the double-dabble (shift/add-3) method.
//  Generalised for width, digit count and signed input, with one shift step per clock.
//  Uses ready/valid handshakes on input and output, with output backpressure and an overflow flag.
//  Sits between datapath counters/ALUs and display/UART formatting logic.
// PARAMETERS
//  INPUT_WIDTH     16  width of i_Binary in bits (>=2)
//  DECIMAL_DIGITS  5   BCD digits produced; o_BCD width = 4*DECIMAL_DIGITS
//  SIGNED          0   1: i_Binary is two's complement, magnitude converted and sign reported
// PORTS
//  i_Clock     in   1        clock; all state on rising edge
//  i_Rst_L     in   1        asynchronous reset, active-low
//  i_Binary    in   INPUT_WIDTH  value to convert; sampled on input handshake
//  i_Valid     in   1        i_Binary valid
//  o_Ready     out  1        converter can accept; handshake = i_Valid & o_Ready
//  o_BCD       out  4*DECIMAL_DIGITS  result, digit 0 in [3:0]
//  o_Sign      out  1        1 = result negative (SIGNED=1 only, else constant 0)
//  o_Overflow  out  1        1 = magnitude >= 10**DECIMAL_DIGITS
//  o_Valid     out  1        o_BCD/o_Sign/o_Overflow valid
//  i_Ready     in   1        downstream accepts; handshake = o_Valid & i_Ready
// BEHAVIOUR
//  Reset (i_Rst_L=0, immediate):
//   - state=IDLE; o_Ready=1; o_Valid=0; o_BCD=0; o_Sign=0; o_Overflow=0.
//   - Bit counter and working registers are cleared.
//   - Reset mid-conversion aborts the conversion and emits no output.
//  State IDLE: o_Ready=1. On input handshake:
//   - capture magnitude: SIGNED && i_Binary[MSB] ? -i_Binary : i_Binary, taken as W-bit unsigned.
//   - latch the sign (0 for SIGNED=0); clear working BCD and sticky overflow.
//   - bit count = INPUT_WIDTH; go to CONVERT.
//  State CONVERT: o_Ready=0. Each cycle performs one step:
//   - every working digit >4 gets +3, all digits corrected in parallel;
//   - then the working BCD shifts left 1 and takes the magnitude MSB into bit 0;
//   - the magnitude shifts left 1;
//   - the bit shifted out of the top of the BCD is ORed into sticky overflow;
//   - count decrements. After the INPUT_WIDTH-th step, go to DONE.
//   - The step's BCD, sign and overflow are loaded into o_BCD/o_Sign/o_Overflow on that same edge.
//  State DONE: o_Valid=1; outputs held stable until output handshake.
//   - On output handshake with no new input: go to IDLE.
//   - o_Ready = i_Ready in DONE, so back-to-back input is allowed: if output and input
//     handshakes happen on the same edge, the new value is captured and the state goes to CONVERT.
//   - o_BCD/o_Sign/o_Overflow keep their last values outside DONE, until the next result loads.
//  Latency: the input handshake at edge k gives o_Valid=1 after edge k+INPUT_WIDTH.
//   - Sustained throughput is one result per INPUT_WIDTH+1 cycles.
//  Overflow: o_BCD = magnitude mod 10**DECIMAL_DIGITS, i.e. low digits are correct and upper digits dropped.
//  Signed edge cases:
//   - most negative input -2**(W-1) converts to magnitude 2**(W-1) with o_Sign=1;
//   - zero always gives o_Sign=0.
//  i_Binary is ignored outside the input handshake.
//   - i_Valid is ignored while o_Ready=0; the upstream holds it.
// TESTING
//  W=8,D=3,S=0: input 255 -> after 8 cycles o_Valid=1, o_BCD=12'h255, o_Overflow=0
//  W=8,D=2,S=0: input 200 -> o_BCD=8'h00, o_Overflow=1; input 99 -> 8'h99, o_Overflow=0
//  W=8,D=3,S=1: input 8'h80 -> o_BCD=12'h128, o_Sign=1; 8'hFF -> 12'h001, o_Sign=1; 8'h00 -> 12'h000, o_Sign=0
//  W=16,D=5: hold i_Ready=0 for 10 cycles after o_Valid -> o_Valid and 20'h65535 (input 65535) stay stable, o_Ready=0
//  Back-to-back: i_Valid=1 and i_Ready=1 in DONE with next value 1234 -> accepted the same edge; next o_Valid=1 after 16 cycles, o_BCD=20'h01234
//  Drive i_Rst_L=0 at CONVERT step 4 -> o_Valid=0 and o_Ready=1 immediately; a new conversion afterwards is correct

Source files
------------

// File: rtl/binary_to_bcd_stream.sv
// binary_to_bcd_stream
//   Streaming binary-to-BCD converter (double dabble, one shift/add-3 step
//   per clock) with ready/valid handshakes on both sides.
//
//   i_Clock     clock, rising edge
//   i_Rst_L     async reset, active low
//   i_Binary    value to convert, sampled on i_Valid & o_Ready
//   i_Valid     input valid
//   o_Ready     converter can accept (IDLE, or DONE while i_Ready=1)
//   o_BCD       result, digit 0 in [3:0]
//   o_Sign      result negative (only when SIGNED=1)
//   o_Overflow  magnitude >= 10**DECIMAL_DIGITS; o_BCD holds the low digits
//   o_Valid     result valid, held until o_Valid & i_Ready
//   i_Ready     downstream accepts

// One BCD digit of the add-3 correction; instanced once per digit.
module bcd_dabble_digit (
  input  logic [3:0] i_Digit,
  output logic [3:0] o_Digit
);
  assign o_Digit = (i_Digit > 4'd4) ? i_Digit + 4'd3 : i_Digit;
endmodule

module binary_to_bcd_stream #(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter int SIGNED         = 0
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic [INPUT_WIDTH-1:0]      i_Binary,
  input  logic                        i_Valid,
  output logic                        o_Ready,
  output logic [4*DECIMAL_DIGITS-1:0] o_BCD,
  output logic                        o_Sign,
  output logic                        o_Overflow,
  output logic                        o_Valid,
  input  logic                        i_Ready
);
  localparam int BW = 4 * DECIMAL_DIGITS;
  localparam int CW = $clog2(INPUT_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t                 r_State, w_Next_State;
  logic [INPUT_WIDTH-1:0] r_Mag;
  logic [BW-1:0]          r_Work;
  logic [CW-1:0]          r_Count;
  logic                   r_Sign_Work;
  logic                   r_Ovf_Work;
  logic [BW-1:0]          r_BCD;
  logic                   r_Sign;
  logic                   r_Overflow;

  logic [BW-1:0]          w_Corr;
  logic [BW-1:0]          w_Shifted;
  logic                   w_Carry;
  logic                   w_Last;
  logic                   w_Load;
  logic                   w_Neg;
  logic [INPUT_WIDTH-1:0] w_Mag_In;

  // Add-3 correction on every working digit in parallel.
  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .i_Digit (r_Work[4*g +: 4]),
      .o_Digit (w_Corr[4*g +: 4])
    );
  end

  // Bit leaving the top of the BCD window means the value no longer fits;
  // dropping it leaves the low digits correct (value mod 10**D).
  assign w_Shifted = {w_Corr[BW-2:0], r_Mag[INPUT_WIDTH-1]};
  assign w_Carry   = w_Corr[BW-1];
  assign w_Last    = (r_Count == CW'(1));

  // Most-negative input negates to itself, which read unsigned is 2**(W-1).
  assign w_Neg    = (SIGNED != 0) && i_Binary[INPUT_WIDTH-1];
  assign w_Mag_In = w_Neg ? -i_Binary : i_Binary;

  // Decoded from state rather than o_Ready to keep the comb logic acyclic.
  assign w_Load = i_Valid && ((r_State == S_IDLE) ||
                              (r_State == S_DONE && i_Ready));

  always_comb begin
    w_Next_State = r_State;
    o_Ready      = 1'b0;
    o_Valid      = 1'b0;
    case (r_State)
      S_IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) w_Next_State = S_CONVERT;
      end
      S_CONVERT: begin
        if (w_Last) w_Next_State = S_DONE;
      end
      S_DONE: begin
        o_Valid = 1'b1;
        o_Ready = i_Ready;  // lets a new input ride the output handshake
        if (i_Ready) w_Next_State = i_Valid ? S_CONVERT : S_IDLE;
      end
      default: w_Next_State = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= S_IDLE;
      r_Mag       <= '0;
      r_Work      <= '0;
      r_Count     <= '0;
      r_Sign_Work <= 1'b0;
      r_Ovf_Work  <= 1'b0;
      r_BCD       <= '0;
      r_Sign      <= 1'b0;
      r_Overflow  <= 1'b0;
    end else begin
      r_State <= w_Next_State;
      if (w_Load) begin
        r_Mag       <= w_Mag_In;
        r_Sign_Work <= w_Neg;
        r_Work      <= '0;
        r_Ovf_Work  <= 1'b0;
        r_Count     <= CW'(INPUT_WIDTH);
      end else if (r_State == S_CONVERT) begin
        r_Work     <= w_Shifted;
        r_Mag      <= {r_Mag[INPUT_WIDTH-2:0], 1'b0};
        r_Ovf_Work <= r_Ovf_Work | w_Carry;
        r_Count    <= r_Count - CW'(1);
        // Final step publishes straight to the output registers.
        if (w_Last) begin
          r_BCD      <= w_Shifted;
          r_Sign     <= r_Sign_Work;
          r_Overflow <= r_Ovf_Work | w_Carry;
        end
      end
    end
  end

  assign o_BCD      = r_BCD;
  assign o_Sign     = r_Sign;
  assign o_Overflow = r_Overflow;
endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// tb_binary_to_bcd_stream
//   Four converter configurations: three 8-bit ones share one input stream
//   (unsigned D=3, unsigned D=2, signed D=3), plus one 16-bit D=5 instance.
//   Expected results come from a decimal-division model, queued at stimulus
//   time and popped when o_Valid is seen.
module tb_binary_to_bcd_stream;
  typedef struct {
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
  } exp_t;

  logic        clk, rst_n;
  logic [7:0]  bin8;
  logic        vld8, rdy8;
  logic [15:0] bin16;
  logic        vld16, rdy16;

  logic        a_rdy, a_sgn, a_ovf, a_vld;
  logic [11:0] a_bcd;
  logic        b_rdy, b_sgn, b_ovf, b_vld;
  logic [7:0]  b_bcd;
  logic        c_rdy, c_sgn, c_ovf, c_vld;
  logic [11:0] c_bcd;
  logic        d_rdy, d_sgn, d_ovf, d_vld;
  logic [19:0] d_bcd;

  int   n_vec, n_err;
  exp_t qA[$], qB[$], qC[$], qD[$];

  binary_to_bcd_stream #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(0)) u_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Binary(bin8), .i_Valid(vld8), .o_Ready(a_rdy),
    .o_BCD(a_bcd), .o_Sign(a_sgn), .o_Overflow(a_ovf), .o_Valid(a_vld), .i_Ready(rdy8));
  binary_to_bcd_stream #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(2), .SIGNED(0)) u_b (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Binary(bin8), .i_Valid(vld8), .o_Ready(b_rdy),
    .o_BCD(b_bcd), .o_Sign(b_sgn), .o_Overflow(b_ovf), .o_Valid(b_vld), .i_Ready(rdy8));
  binary_to_bcd_stream #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(1)) u_c (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Binary(bin8), .i_Valid(vld8), .o_Ready(c_rdy),
    .o_BCD(c_bcd), .o_Sign(c_sgn), .o_Overflow(c_ovf), .o_Valid(c_vld), .i_Ready(rdy8));
  binary_to_bcd_stream #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED(0)) u_d (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Binary(bin16), .i_Valid(vld16), .o_Ready(d_rdy),
    .o_BCD(d_bcd), .o_Sign(d_sgn), .o_Overflow(d_ovf), .o_Valid(d_vld), .i_Ready(rdy16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input int unsigned bin, input int w, input int d, input bit s);
    exp_t        e;
    int unsigned mask, b, mag, lim, m;
    mask   = (32'd1 << w) - 1;
    b      = bin & mask;
    e.sign = s && (((b >> (w - 1)) & 1) != 0);
    mag    = e.sign ? (((32'd1 << w) - b) & mask) : b;
    lim    = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    e.bcd = '0;
    m     = mag;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    vld8 = 1'b0; rdy8 = 1'b0; bin8 = '0;
    vld16 = 1'b0; rdy16 = 1'b0; bin16 = '0;
    #12;
    n_vec++;
    if ({a_rdy, a_vld, a_bcd, a_sgn, a_ovf} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_a: rdy=%b vld=%b bcd=%h sgn=%b ovf=%b, want 1 0 000 0 0", a_rdy, a_vld, a_bcd, a_sgn, a_ovf);
    end
    n_vec++;
    if ({b_rdy, b_vld, b_bcd, b_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL reset_b: rdy=%b vld=%b bcd=%h ovf=%b, want 1 0 00 0", b_rdy, b_vld, b_bcd, b_ovf);
    end
    n_vec++;
    if ({c_rdy, c_vld, c_bcd, c_sgn} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
      n_err++; $display("FAIL reset_c: rdy=%b vld=%b bcd=%h sgn=%b, want 1 0 000 0", c_rdy, c_vld, c_bcd, c_sgn);
    end
    n_vec++;
    if ({d_rdy, d_vld, d_bcd, d_ovf} !== {1'b1, 1'b0, 20'h00000, 1'b0}) begin
      n_err++; $display("FAIL reset_d: rdy=%b vld=%b bcd=%h ovf=%b, want 1 0 00000 0", d_rdy, d_vld, d_bcd, d_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 8-bit stream: every value goes through all three 8-bit configurations.
  task automatic test_convert8();
    int unsigned vals[14];
    exp_t        ea, eb, ec;
    int          cyc;
    vals = '{255, 200, 99, 128, 0, 1, 100, 127, 9, 10, 0, 0, 0, 0};
    for (int i = 10; i < 14; i++) vals[i] = $urandom_range(0, 255);
    for (int i = 0; i < 14; i++) begin
      qA.push_back(model(vals[i], 8, 3, 0));
      qB.push_back(model(vals[i], 8, 2, 0));
      qC.push_back(model(vals[i], 8, 3, 1));
      bin8 = 8'(vals[i]);
      vld8 = 1'b1;
      cyc = 0;
      while (!a_rdy && cyc < 40) begin @(negedge clk); cyc++; end
      @(negedge clk);
      vld8 = 1'b0;
      bin8 = ~bin8;  // must be ignored outside the handshake
      cyc = 0;
      while (!a_vld && cyc < 40) begin @(negedge clk); cyc++; end
      n_vec++;
      if (cyc != 8) begin
        n_err++; $display("FAIL latency8 val=%0d: got %0d cycles, want 8", vals[i], cyc);
      end
      ea = qA.pop_front(); eb = qB.pop_front(); ec = qC.pop_front();
      n_vec++;
      if ({a_bcd, a_sgn, a_ovf} !== {ea.bcd[11:0], ea.sign, ea.ovf}) begin
        n_err++; $display("FAIL conv_a val=%0d: bcd=%h sgn=%b ovf=%b, want %h %b %b", vals[i], a_bcd, a_sgn, a_ovf, ea.bcd[11:0], ea.sign, ea.ovf);
      end
      n_vec++;
      if ({b_vld, b_bcd, b_sgn, b_ovf} !== {1'b1, eb.bcd[7:0], eb.sign, eb.ovf}) begin
        n_err++; $display("FAIL conv_b val=%0d: vld=%b bcd=%h sgn=%b ovf=%b, want 1 %h %b %b", vals[i], b_vld, b_bcd, b_sgn, b_ovf, eb.bcd[7:0], eb.sign, eb.ovf);
      end
      n_vec++;
      if ({c_vld, c_bcd, c_sgn, c_ovf} !== {1'b1, ec.bcd[11:0], ec.sign, ec.ovf}) begin
        n_err++; $display("FAIL conv_c val=%0d: vld=%b bcd=%h sgn=%b ovf=%b, want 1 %h %b %b", vals[i], c_vld, c_bcd, c_sgn, c_ovf, ec.bcd[11:0], ec.sign, ec.ovf);
      end
      rdy8 = 1'b1;
      @(negedge clk);
      rdy8 = 1'b0;
      n_vec++;
      if ({a_vld, a_rdy, a_bcd} !== {1'b0, 1'b1, ea.bcd[11:0]}) begin
        n_err++; $display("FAIL accept8 val=%0d: vld=%b rdy=%b bcd=%h, want 0 1 %h", vals[i], a_vld, a_rdy, a_bcd, ea.bcd[11:0]);
      end
    end
  endtask

  // 16-bit: hold result under backpressure, then a back-to-back input.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc, bad;
    qD.push_back(model(65535, 16, 5, 0));
    bin16 = 16'd65535;
    vld16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    cyc = 0;
    while (!d_vld && cyc < 60) begin @(negedge clk); cyc++; end
    n_vec++;
    if (cyc != 16) begin
      n_err++; $display("FAIL latency16: got %0d cycles, want 16", cyc);
    end
    e = qD.pop_front();
    n_vec++;
    if ({d_bcd, d_ovf} !== {e.bcd, e.ovf}) begin
      n_err++; $display("FAIL conv_65535: bcd=%h ovf=%b, want %h %b", d_bcd, d_ovf, e.bcd, e.ovf);
    end
    // Upstream offers a value while the converter is blocked; it must be ignored.
    vld16 = 1'b1;
    bin16 = 16'd777;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_vld !== 1'b1 || d_rdy !== 1'b0 || d_bcd !== 20'h65535) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL hold16: %0d unstable cycles, want 0 (last vld=%b rdy=%b bcd=%h)", bad, d_vld, d_rdy, d_bcd);
    end
    qD.push_back(model(1234, 16, 5, 0));
    bin16 = 16'd1234;
    rdy16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    rdy16 = 1'b0;
    bin16 = 16'hBEEF;
    n_vec++;
    if ({d_vld, d_rdy} !== 2'b00) begin
      n_err++; $display("FAIL b2b_accept: vld=%b rdy=%b, want 0 0", d_vld, d_rdy);
    end
    cyc = 0;
    while (!d_vld && cyc < 60) begin @(negedge clk); cyc++; end
    n_vec++;
    if (cyc != 16) begin
      n_err++; $display("FAIL b2b_latency: got %0d cycles, want 16", cyc);
    end
    e = qD.pop_front();
    n_vec++;
    if ({d_bcd, d_ovf, d_sgn} !== {e.bcd, e.ovf, e.sign}) begin
      n_err++; $display("FAIL b2b_value: bcd=%h ovf=%b sgn=%b, want %h %b %b", d_bcd, d_ovf, d_sgn, e.bcd, e.ovf, e.sign);
    end
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
  endtask

  // Reset during a conversion aborts it; the next conversion is clean.
  task automatic test_reset_mid();
    exp_t e;
    int   cyc, bad;
    bin16 = 16'd500;
    vld16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({d_vld, d_rdy, d_bcd} !== {1'b0, 1'b1, 20'h00000}) begin
      n_err++; $display("FAIL reset_mid: vld=%b rdy=%b bcd=%h, want 0 1 00000", d_vld, d_rdy, d_bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (d_vld !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL abort_no_output: o_Valid high %0d cycles, want 0", bad);
    end
    qD.push_back(model(4321, 16, 5, 0));
    bin16 = 16'd4321;
    vld16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    cyc = 0;
    while (!d_vld && cyc < 60) begin @(negedge clk); cyc++; end
    e = qD.pop_front();
    n_vec++;
    if (cyc != 16 || d_bcd !== e.bcd || d_ovf !== e.ovf) begin
      n_err++; $display("FAIL after_reset: cycles=%0d bcd=%h ovf=%b, want 16 %h %b", cyc, d_bcd, d_ovf, e.bcd, e.ovf);
    end
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_convert8();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
